// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: register file, forwarding network, load-use and HI/LO
// hazard stalls, multiply/divide countdown feeding HI/LO, and the ID/EX operand register.
module id_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int FWD_N   = 2,
    parameter int MDU_LAT = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_rs,
    input  logic [AW-1:0]         id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_is_jal,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [1:0]            id_rd_hilo,
    input  logic                  id_mdu_start,
    input  logic [XLEN-1:0]       mdu_hi_in,
    input  logic [XLEN-1:0]       mdu_lo_in,
    input  logic [FWD_N-1:0]      fwd_we,
    input  logic [FWD_N*AW-1:0]   fwd_rd,
    input  logic [FWD_N*XLEN-1:0] fwd_data,
    input  logic [FWD_N-1:0]      fwd_is_load,
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_op1,
    output logic [XLEN-1:0]       ex_op2,
    output logic                  mdu_busy
);
    localparam int CW = $clog2(MDU_LAT + 1);

    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] hi, lo;
    logic [CW-1:0]   mdu_cnt;

    logic [XLEN-1:0] src1_p0, src2_p0, op1_p0, op2_p0;
    logic            load1_p0, load2_p0, rd_hi_p0, rd_lo_p0, accept_p0;

    // Lowest forwarding index wins, so scan from the oldest source down to the youngest.
    function automatic logic [XLEN-1:0] select_src(input logic [AW-1:0] src,
                                                   output logic load_hit);
        logic [XLEN-1:0] val;
        load_hit = 1'b0;
        val      = '0;
        if (src != '0) begin
            val = (wb_we && wb_rd == src) ? wb_data : rf[src];
            for (int i = FWD_N - 1; i >= 0; i--) begin
                if (fwd_we[i] && fwd_rd[i*AW +: AW] == src) begin
                    val      = fwd_data[i*XLEN +: XLEN];
                    load_hit = fwd_is_load[i];
                end
            end
        end
        return val;
    endfunction

    // ---- ID stage: operand selection and hazard detection ----
    always_comb begin
        load1_p0 = 1'b0;
        load2_p0 = 1'b0;
        src1_p0  = select_src(id_rs, load1_p0);
        src2_p0  = select_src(id_rt, load2_p0);
        rd_hi_p0 = (id_rd_hilo == 2'b01);
        rd_lo_p0 = (id_rd_hilo == 2'b10);

        op1_p0 = src1_p0;
        op2_p0 = src2_p0;
        if (id_is_jal) begin
            op1_p0 = id_pc + XLEN'(8);
            op2_p0 = '0;
        end else if (rd_hi_p0) begin
            op1_p0 = hi;
            op2_p0 = '0;
        end else if (rd_lo_p0) begin
            op1_p0 = lo;
            op2_p0 = '0;
        end
    end

    assign mdu_busy  = (mdu_cnt != '0);
    assign stall     = id_valid && !ex_flush &&
                       ((id_use_rs && load1_p0) || (id_use_rt && load2_p0) ||
                        ((rd_hi_p0 || rd_lo_p0) && mdu_busy) ||
                        (id_mdu_start && mdu_busy));
    assign accept_p0 = id_valid && id_mdu_start && !stall && !ex_flush;

    // ---- ID/EX boundary, regfile, HI/LO and MDU countdown ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            hi       <= '0;
            lo       <= '0;
            mdu_cnt  <= '0;
            ex_valid <= 1'b0;
            ex_op1   <= '0;
            ex_op2   <= '0;
        end else begin
            if (wb_we && wb_rd != '0) rf[wb_rd] <= wb_data;

            if (mdu_cnt == CW'(1)) begin
                hi <= mdu_hi_in;
                lo <= mdu_lo_in;
            end

            if (accept_p0)     mdu_cnt <= CW'(MDU_LAT);
            else if (mdu_busy) mdu_cnt <= mdu_cnt - CW'(1);

            if (ex_flush || stall || !id_valid) begin
                ex_valid <= 1'b0;
                ex_op1   <= '0;
                ex_op2   <= '0;
            end else begin
                ex_valid <= 1'b1;
                ex_op1   <= op1_p0;
                ex_op2   <= op2_p0;
            end
        end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios plus randomized traffic against a
// cycle-indexed behavioural model of registers, HI/LO and MDU completion time.
module tb_id_operand_stage;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int FWD_N = 2;
    localparam int LAT   = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  id_valid, id_use_rs, id_use_rt, id_is_jal, id_mdu_start;
    logic [AW-1:0]         id_rs, id_rt, wb_rd;
    logic [XLEN-1:0]       id_pc, mdu_hi_in, mdu_lo_in, wb_data;
    logic [1:0]            id_rd_hilo;
    logic [FWD_N-1:0]      fwd_we, fwd_is_load;
    logic [FWD_N*AW-1:0]   fwd_rd;
    logic [FWD_N*XLEN-1:0] fwd_data;
    logic                  wb_we, ex_flush;
    logic                  stall, ex_valid, mdu_busy;
    logic [XLEN-1:0]       ex_op1, ex_op2;

    always #5 clk = ~clk;

    id_operand_stage #(.XLEN(XLEN), .NREG(NREG), .FWD_N(FWD_N), .MDU_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_jal(id_is_jal), .id_pc(id_pc),
        .id_rd_hilo(id_rd_hilo), .id_mdu_start(id_mdu_start), .mdu_hi_in(mdu_hi_in),
        .mdu_lo_in(mdu_lo_in), .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd_is_load(fwd_is_load), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .mdu_busy(mdu_busy)
    );

    // Reference state: register contents, HI/LO, and the edge index of the last MDU accept.
    logic [XLEN-1:0] m_rf [NREG];
    logic [XLEN-1:0] m_hi, m_lo;
    int              m_edge = 0;
    int              m_acc  = -100;
    logic            exp_stall, exp_busy, exp_valid, act_stall, act_busy;
    logic [XLEN-1:0] exp_op1, exp_op2;
    int              n_cmp = 0;
    int              n_fail = 0;

    function automatic logic [XLEN-1:0] m_operand(input logic [AW-1:0] src, output logic is_ld);
        is_ld = 1'b0;
        if (src == 0) return '0;
        for (int i = 0; i < FWD_N; i++) begin
            if (fwd_we[i] && fwd_rd[i*AW +: AW] == src) begin
                is_ld = fwd_is_load[i];
                return fwd_data[i*XLEN +: XLEN];
            end
        end
        if (wb_we && wb_rd == src) return wb_data;
        return m_rf[src];
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_jal = 0;
        id_pc = 0; id_rd_hilo = 0; id_mdu_start = 0; mdu_hi_in = 0; mdu_lo_in = 0;
        fwd_we = 0; fwd_rd = 0; fwd_data = 0; fwd_is_load = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
    endtask

    // One clock: predict, sample combinational outputs, clock, then advance the model.
    task automatic step();
        logic ld1, ld2, busy, acc;
        logic [XLEN-1:0] o1, o2;
        #2;
        busy = (m_edge - m_acc) < LAT;
        o1 = m_operand(id_rs, ld1);
        o2 = m_operand(id_rt, ld2);
        exp_stall = id_valid && !ex_flush && ((id_use_rs && ld1) || (id_use_rt && ld2) ||
                    ((id_rd_hilo == 2'b01 || id_rd_hilo == 2'b10) && busy) ||
                    (id_mdu_start && busy));
        exp_busy = busy;
        if (id_is_jal) begin o1 = id_pc + 32'd8; o2 = 0; end
        else if (id_rd_hilo == 2'b01) begin o1 = m_hi; o2 = 0; end
        else if (id_rd_hilo == 2'b10) begin o1 = m_lo; o2 = 0; end
        acc = id_valid && id_mdu_start && !exp_stall && !ex_flush;
        act_stall = stall;
        act_busy  = mdu_busy;
        @(posedge clk);
        m_edge++;
        if (!reset) begin
            for (int i = 0; i < NREG; i++) m_rf[i] = 0;
            m_hi = 0; m_lo = 0; m_acc = -100;
            exp_valid = 0; exp_op1 = 0; exp_op2 = 0;
        end else begin
            if (m_edge == m_acc + LAT) begin m_hi = mdu_hi_in; m_lo = mdu_lo_in; end
            if (acc) m_acc = m_edge;
            if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
            if (ex_flush || exp_stall || !id_valid) begin
                exp_valid = 0; exp_op1 = 0; exp_op2 = 0;
            end else begin
                exp_valid = 1; exp_op1 = o1; exp_op2 = o2;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 0; clear_inputs();
        step(); step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset ex_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_op1 !== 32'h0) begin n_fail++; $display("FAIL reset ex_op1: got %h want 0", ex_op1); end
        n_cmp++; if (ex_op2 !== 32'h0) begin n_fail++; $display("FAIL reset ex_op2: got %h want 0", ex_op2); end
        n_cmp++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset mdu_busy: got %b want 0", mdu_busy); end
        reset = 1;
    endtask

    task automatic test_wb_read();
        clear_inputs(); wb_we = 1; wb_rd = 5; wb_data = 32'h1234;
        step();
        clear_inputs(); id_valid = 1; id_rs = 5; id_use_rs = 1;
        step();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL wb_read ex_valid: got %b want 1", ex_valid); end
        n_cmp++; if (ex_op1 !== 32'h1234) begin n_fail++; $display("FAIL wb_read ex_op1: got %h want 1234", ex_op1); end
    endtask

    task automatic test_bypass();
        clear_inputs(); wb_we = 1; wb_rd = 7; wb_data = 32'hAA;
        fwd_we = 2'b11; fwd_rd = {5'd7, 5'd7}; fwd_data = {32'hBB, 32'hCC};
        id_valid = 1; id_rt = 7; id_use_rt = 1;
        step();
        n_cmp++; if (ex_op2 !== 32'hCC) begin n_fail++; $display("FAIL bypass_fwd0: got %h want cc", ex_op2); end
        fwd_we = 2'b10;
        step();
        n_cmp++; if (ex_op2 !== 32'hBB) begin n_fail++; $display("FAIL bypass_fwd1: got %h want bb", ex_op2); end
        fwd_we = 2'b00;
        step();
        n_cmp++; if (ex_op2 !== 32'hAA) begin n_fail++; $display("FAIL bypass_wb: got %h want aa", ex_op2); end
    endtask

    task automatic test_load_use();
        clear_inputs(); fwd_we = 2'b01; fwd_rd = {5'd0, 5'd3}; fwd_is_load = 2'b01;
        id_valid = 1; id_rs = 3; id_use_rs = 1;
        step();
        n_cmp++; if (act_stall !== 1'b1) begin n_fail++; $display("FAIL load_use stall: got %b want 1", act_stall); end
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL load_use bubble: got %b want 0", ex_valid); end
        fwd_we = 2'b10; fwd_rd = {5'd3, 5'd0}; fwd_is_load = 0; fwd_data = {32'h55, 32'h0};
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL load_done stall: got %b want 0", act_stall); end
        n_cmp++; if (ex_op1 !== 32'h55) begin n_fail++; $display("FAIL load_done op1: got %h want 55", ex_op1); end
        fwd_we = 2'b01; fwd_rd = {5'd0, 5'd3}; fwd_is_load = 2'b01; id_use_rs = 0;
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL load_unused stall: got %b want 0", act_stall); end
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL load_unused valid: got %b want 1", ex_valid); end
    endtask

    task automatic test_mdu();
        clear_inputs(); id_valid = 1; id_mdu_start = 1;
        mdu_hi_in = 32'hDEAD; mdu_lo_in = 32'hBEEF;
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL mdu_accept stall: got %b want 0", act_stall); end
        n_cmp++; if (mdu_busy !== 1'b1) begin n_fail++; $display("FAIL mdu_accept busy: got %b want 1", mdu_busy); end
        id_mdu_start = 0; id_rd_hilo = 2'b01;
        for (int k = 0; k < LAT; k++) begin
            step();
            n_cmp++; if (act_stall !== 1'b1) begin n_fail++; $display("FAIL mfhi_wait%0d stall: got %b want 1", k, act_stall); end
            n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL mfhi_wait%0d valid: got %b want 0", k, ex_valid); end
        end
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL mfhi stall: got %b want 0", act_stall); end
        n_cmp++; if (ex_op1 !== 32'hDEAD) begin n_fail++; $display("FAIL mfhi op1: got %h want dead", ex_op1); end
        id_rd_hilo = 2'b10;
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL mflo stall: got %b want 0", act_stall); end
        n_cmp++; if (ex_op1 !== 32'hBEEF) begin n_fail++; $display("FAIL mflo op1: got %h want beef", ex_op1); end
    endtask

    task automatic test_jal_zero();
        clear_inputs(); id_valid = 1; id_is_jal = 1; id_pc = 32'hFFFF_FFFC; id_rs = 5; id_use_rs = 1;
        step();
        n_cmp++; if (ex_op1 !== 32'h4) begin n_fail++; $display("FAIL jal op1: got %h want 4", ex_op1); end
        n_cmp++; if (ex_op2 !== 32'h0) begin n_fail++; $display("FAIL jal op2: got %h want 0", ex_op2); end
        clear_inputs(); id_valid = 1; id_use_rs = 1; fwd_we = 2'b11; fwd_rd = 0;
        fwd_data = {32'h77, 32'h66}; fwd_is_load = 2'b11;
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL r0 stall: got %b want 0", act_stall); end
        n_cmp++; if (ex_op1 !== 32'h0) begin n_fail++; $display("FAIL r0 op1: got %h want 0", ex_op1); end
    endtask

    task automatic test_flush();
        clear_inputs(); id_valid = 1; id_mdu_start = 1; ex_flush = 1;
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle valid: got %b want 0", ex_valid); end
        n_cmp++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy: got %b want 0", mdu_busy); end
        ex_flush = 0;
        step();
        ex_flush = 1;
        step();
        n_cmp++; if (act_stall !== 1'b0) begin n_fail++; $display("FAIL flush_busy stall: got %b want 0", act_stall); end
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy valid: got %b want 0", ex_valid); end
        clear_inputs();
        repeat (LAT) step();
    endtask

    task automatic test_reset_midcount();
        clear_inputs(); id_valid = 1; id_mdu_start = 1; mdu_hi_in = 32'h1111; mdu_lo_in = 32'h2222;
        step();
        id_valid = 0; id_mdu_start = 0;
        step();
        reset = 0;
        step();
        reset = 1;
        n_cmp++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", mdu_busy); end
        repeat (3) step();
        id_valid = 1; id_rd_hilo = 2'b01;
        step();
        n_cmp++; if (ex_op1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid hi: got %h want 0", ex_op1); end
        id_rd_hilo = 2'b00; id_rs = 5; id_use_rs = 1;
        step();
        n_cmp++; if (ex_op1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid r5: got %h want 0", ex_op1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 59) != 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs        = AW'($urandom_range(0, 7));
            id_rt        = AW'($urandom_range(0, 7));
            id_use_rs    = 1'($urandom);
            id_use_rt    = 1'($urandom);
            id_is_jal    = ($urandom_range(0, 7) == 0);
            id_pc        = $urandom;
            id_rd_hilo   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            id_mdu_start = ($urandom_range(0, 5) == 0);
            mdu_hi_in    = $urandom;
            mdu_lo_in    = $urandom;
            fwd_we       = 2'($urandom);
            fwd_rd       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            fwd_data     = {$urandom, $urandom};
            fwd_is_load  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            wb_we        = 1'($urandom);
            wb_rd        = AW'($urandom_range(0, 7));
            wb_data      = $urandom;
            ex_flush     = ($urandom_range(0, 7) == 0);
            step();
            n_cmp++; if (act_stall !== exp_stall) begin n_fail++; $display("FAIL rnd%0d stall: got %b want %b", n, act_stall, exp_stall); end
            n_cmp++; if (act_busy !== exp_busy) begin n_fail++; $display("FAIL rnd%0d busy: got %b want %b", n, act_busy, exp_busy); end
            n_cmp++; if (ex_valid !== exp_valid) begin n_fail++; $display("FAIL rnd%0d valid: got %b want %b", n, ex_valid, exp_valid); end
            n_cmp++; if (ex_op1 !== exp_op1) begin n_fail++; $display("FAIL rnd%0d op1: got %h want %h", n, ex_op1, exp_op1); end
            n_cmp++; if (ex_op2 !== exp_op2) begin n_fail++; $display("FAIL rnd%0d op2: got %h want %h", n, ex_op2, exp_op2); end
        end
        reset = 1;
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_wb_read();
        test_bypass();
        test_load_use();
        test_mdu();
        test_jal_zero();
        test_flush();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised decode-stage operand unit for the pipelined CPU: register file, N-source forwarding network, load-use and HI/LO hazard stalls, registered ID/EX operand outputs.
- Adds architecturally real HI/LO registers fed by a fixed-latency multiply/divide countdown, so mfhi/mflo return real data instead of zero.
- Sits between the IF/ID register and the EX stage; its stall output holds PC and IF/ID.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural register count; power of two, ≥2; AW = $clog2(NREG).
- FWD_N, 2, number of forwarding sources; index 0 is the youngest (EXE), then MEM.
- MDU_LAT, 4, cycles from multiply/divide issue to HI/LO update; ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register indices.
- id_use_rs, id_use_rt  in  1  source actually read (gates hazard checks).
- id_is_jal  in  1  link instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rd_hilo  in  2  00 none, 01 mfhi, 10 mflo, 11 reserved (treated as 00).
- id_mdu_start  in  1  ID instruction is mult/div.
- mdu_hi_in, mdu_lo_in  in  XLEN  MDU result, sampled at completion.
- fwd_we  in  FWD_N  source i will write a register.
- fwd_rd  in  FWD_N*AW  destination of source i; slice i at [i*AW +: AW].
- fwd_data  in  FWD_N*XLEN  value of source i.
- fwd_is_load  in  FWD_N  source i is a load whose data is not yet valid.
- wb_we  in  1  regfile write enable.
- wb_rd  in  AW  regfile write index.
- wb_data  in  XLEN  regfile write data.
- ex_flush  in  1  squash the ID instruction (branch/jump redirect).
- stall  out  1  combinational; hold PC and IF/ID.
- ex_valid  out  1  registered; ID/EX holds a valid instruction.
- ex_op1, ex_op2  out  XLEN  registered operands.
- mdu_busy  out  1  combinational; mdu_cnt != 0.

Behaviour:
- Reset (reset == 0 at a clk edge): all registers 0, HI = LO = 0, mdu_cnt = 0, ex_valid = 0, ex_op1 = ex_op2 = 0. Any in-flight MDU result is discarded.
- Register 0 always reads 0. It is never written, never forwarded, and never causes a hazard.

Regfile:
- Write at the clk edge when wb_we && wb_rd != 0.
- Same-cycle read of wb_rd returns wb_data (write-through).

Operand select, per source, for op1 (rs) and op2 (rt):
- Index 0 gives 0.
- Otherwise use the lowest-index i with fwd_we[i] && fwd_rd[i] == src, giving fwd_data[i].
- Otherwise, if wb_we && wb_rd == src, use wb_data.
- Otherwise use the regfile.
- Overrides, in priority order:
  - jal: op1 = id_pc + 8 (mod 2^XLEN), op2 = 0.
  - mfhi: op1 = HI, op2 = 0.
  - mflo: op1 = LO, op2 = 0.

stall is asserted when id_valid && !ex_flush and any of the following holds:
- load-use: a used, nonzero source whose selected (lowest-index) match has fwd_is_load[i] = 1;
- id_rd_hilo ∈ {01, 10} && mdu_cnt != 0;
- id_mdu_start && mdu_cnt != 0.

ID/EX update at each clk edge:
- If ex_flush, stall, or !id_valid: ex_valid <= 0, ex_op1 <= 0, ex_op2 <= 0 (bubble).
- Otherwise: ex_valid <= 1, with the selected operands.
- ex_flush overrides stall.

MDU countdown:
- Accept = id_valid && id_mdu_start && !stall && !ex_flush. On accept, mdu_cnt <= MDU_LAT.
- Otherwise, if mdu_cnt != 0, mdu_cnt decrements.
- On the edge where mdu_cnt == 1: HI <= mdu_hi_in, LO <= mdu_lo_in.
- mfhi/mflo are released the cycle after that edge and read the new HI/LO.
- Accept while mdu_cnt != 0 is impossible (stalled).
- A flushed mult/div never starts.

Test Plan:
- Reset, then write r5 = 0x1234 via WB; next cycle ID rs = 5 → ex_op1 = 0x1234, ex_valid = 1.
- Same-cycle bypass: WB writes r7 = 0xAA, fwd[1] rd = 7 data 0xBB, fwd[0] rd = 7 data 0xCC, ID rt = 7 → ex_op2 = 0xCC. Drop fwd[0] → 0xBB. Drop both → 0xAA.
- Load-use: fwd[0] rd = 3, is_load = 1, ID uses rs = 3 → stall = 1 and ex_valid = 0 for that cycle. Next cycle fwd[1] carries data 0x55, not a load → ex_op1 = 0x55. The same with id_use_rs = 0 gives no stall.
- MDU (MDU_LAT = 4): accept mult with mdu_hi_in = 0xDEAD, mdu_lo_in = 0xBEEF, then mfhi immediately → stall for 4 cycles, then ex_op1 = 0xDEAD. A following mflo gives 0xBEEF with no stall.
- jal with id_pc = 0xFFFFFFFC → ex_op1 = 0x00000004, ex_op2 = 0. rs = 0 with fwd_rd = 0 and fwd_we = 1 → ex_op1 = 0.
- ex_flush asserted with a stalling mult in ID → stall = 0, ex_valid = 0, mdu_busy stays 0. Reset asserted mid-countdown → HI/LO = 0, mdu_busy = 0 next cycle.
